// File: rtl/arp_lookup_reply_tracker_pkg.sv
// Shared widths and reply layouts for the ARP lookup reply tracker.
// Stack replies carry {hit, MAC}; user replies add the looked-up IP and a timeout flag.
package arp_lookup_reply_tracker_pkg;

    localparam int ARP_LUP_REQ_BITS   = 32;
    localparam int ARP_LUP_RSP_BITS   = 56;
    localparam int ARP_LUP_RSP_U_BITS = 96;

    typedef struct packed {
        logic [6:0]  rsvd;
        logic        hit;
        logic [47:0] mac;
    } arp_lup_rsp_t;

    typedef struct packed {
        logic [31:0] ip;
        logic [13:0] rsvd;
        logic        timeout;
        logic        hit;
        logic [47:0] mac;
    } arp_lup_rsp_u_t;

    function automatic arp_lup_rsp_u_t make_user_rsp(
        input logic [31:0] ip,
        input logic        timeout,
        input logic        hit,
        input logic [47:0] mac
    );
        arp_lup_rsp_u_t r;
        r.ip      = ip;
        r.rsvd    = '0;
        r.timeout = timeout;
        r.hit     = hit;
        r.mac     = mac;
        return r;
    endfunction

endpackage

// File: rtl/arp_lookup_reply_tracker_meta_reg_slice.sv
// Two-entry valid/ready register slice: registered valid, data and ready,
// one transfer per cycle sustained; the skid entry absorbs the registered-ready lag.
module meta_reg_slice
    import arp_lookup_reply_tracker_pkg::*;
#(
    parameter int DATA_BITS = ARP_LUP_RSP_U_BITS
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [DATA_BITS-1:0] s_data_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [DATA_BITS-1:0] m_data_o
);

    logic                 main_valid_q, main_valid_d;
    logic [DATA_BITS-1:0] main_data_q, main_data_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [DATA_BITS-1:0] skid_data_q, skid_data_d;
    logic                 push;

    assign s_ready_o = !skid_valid_q;
    assign m_valid_o = main_valid_q;
    assign m_data_o  = main_data_q;
    assign push      = s_valid_i && !skid_valid_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!main_valid_q || m_ready_i) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = push;
                if (push) begin
                    main_data_d = s_data_i;
                end
            end
        end else if (push) begin
            // Downstream stalled while ready was still advertised: park in skid.
            skid_valid_d = 1'b1;
            skid_data_d  = s_data_i;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/arp_lookup_reply_tracker.sv
// Pairs stack ARP replies with the IPs of in-flight lookups, in request order,
// answering overdue lookups with a timeout reply and discarding late/spurious ones.
module arp_lookup_reply_tracker
    import arp_lookup_reply_tracker_pkg::*;
#(
    parameter int N_STAGES       = 2,
    parameter int N_OUTSTANDING  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    // Handshakes: a transfer occurs on a rising edge where valid and ready are both
    // high; once valid is raised it stays high with stable data until that transfer.
    input  logic                          s_arp_lookup_request_u_valid_i,
    output logic                          s_arp_lookup_request_u_ready_o,
    input  logic [ARP_LUP_REQ_BITS-1:0]   s_arp_lookup_request_u_data_i,
    output logic                          m_arp_lookup_request_n_valid_o,
    input  logic                          m_arp_lookup_request_n_ready_i,
    output logic [ARP_LUP_REQ_BITS-1:0]   m_arp_lookup_request_n_data_o,
    input  logic                          s_arp_lookup_reply_n_valid_i,
    output logic                          s_arp_lookup_reply_n_ready_o,
    input  logic [ARP_LUP_RSP_BITS-1:0]   s_arp_lookup_reply_n_data_i,
    output logic                          m_arp_lookup_reply_u_valid_o,
    input  logic                          m_arp_lookup_reply_u_ready_i,
    output logic [ARP_LUP_RSP_U_BITS-1:0] m_arp_lookup_reply_u_data_o,
    output logic [31:0]                   m_timeout_cnt_o,
    output logic [31:0]                   m_spurious_cnt_o
);

    localparam int AW   = $clog2(N_OUTSTANDING);
    localparam int PW   = AW + 1;
    localparam int DW   = AW + 1;
    localparam int AGEW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AGEW-1:0] AGE_MAX  = AGEW'(TIMEOUT_CYCLES);
    localparam logic [DW-1:0]   DROP_MAX = '1;

    logic [ARP_LUP_REQ_BITS-1:0] q_mem [N_OUTSTANDING];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AGEW-1:0] age_q, age_d;
    logic [DW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [31:0]     timeout_cnt_q, timeout_cnt_d, spurious_cnt_q, spurious_cnt_d;
    arp_lup_rsp_u_t  oreg_q, oreg_d;
    logic            oreg_valid_q, oreg_valid_d;

    logic         full, empty, push, pop;
    logic         slice_ready, oreg_can_load;
    logic         rsp_hs, rsp_pop, rsp_discard, rsp_drop_owed, to_pop;
    logic [31:0]  head_ip;
    arp_lup_rsp_t rsp_in;
    logic         rsp_rsvd_unused;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head_ip = q_mem[rd_ptr_q[AW-1:0]];

    assign s_arp_lookup_request_u_ready_o = m_arp_lookup_request_n_ready_i && !full;
    assign m_arp_lookup_request_n_valid_o = s_arp_lookup_request_u_valid_i && !full;
    assign m_arp_lookup_request_n_data_o  = s_arp_lookup_request_u_data_i;
    assign push = s_arp_lookup_request_u_valid_i && m_arp_lookup_request_n_ready_i && !full;

    assign rsp_in          = arp_lup_rsp_t'(s_arp_lookup_reply_n_data_i);
    assign rsp_rsvd_unused = ^rsp_in.rsvd;

    assign oreg_can_load = !oreg_valid_q || slice_ready;
    assign s_arp_lookup_reply_n_ready_o = oreg_can_load;
    assign rsp_hs        = s_arp_lookup_reply_n_valid_i && oreg_can_load;
    assign rsp_drop_owed = rsp_hs && (drop_cnt_q != '0);
    assign rsp_pop       = rsp_hs && (drop_cnt_q == '0) && !empty;
    assign rsp_discard   = rsp_hs && !rsp_pop;
    // A real reply wins; the timeout is re-evaluated next cycle on the new head.
    assign to_pop        = !rsp_hs && oreg_can_load && !empty && (age_q == AGE_MAX);
    assign pop           = rsp_pop || to_pop;

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        age_d          = age_q;
        drop_cnt_d     = drop_cnt_q;
        timeout_cnt_d  = timeout_cnt_q;
        spurious_cnt_d = spurious_cnt_q;
        oreg_d         = oreg_q;
        oreg_valid_d   = oreg_valid_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        if (empty || pop) begin
            age_d = '0;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + AGEW'(1);
        end

        if (rsp_drop_owed) drop_cnt_d = drop_cnt_q - DW'(1);
        if (to_pop && drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + DW'(1);
        if (to_pop) timeout_cnt_d = timeout_cnt_q + 32'd1;
        if (rsp_discard) spurious_cnt_d = spurious_cnt_q + 32'd1;

        if (rsp_pop) begin
            oreg_d       = make_user_rsp(head_ip, 1'b0, rsp_in.hit, rsp_in.mac);
            oreg_valid_d = 1'b1;
        end else if (to_pop) begin
            oreg_d       = make_user_rsp(head_ip, 1'b1, 1'b0, 48'h0);
            oreg_valid_d = 1'b1;
        end else if (slice_ready) begin
            oreg_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            age_q          <= '0;
            drop_cnt_q     <= '0;
            timeout_cnt_q  <= '0;
            spurious_cnt_q <= '0;
            oreg_q         <= '0;
            oreg_valid_q   <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            age_q          <= age_d;
            drop_cnt_q     <= drop_cnt_d;
            timeout_cnt_q  <= timeout_cnt_d;
            spurious_cnt_q <= spurious_cnt_d;
            oreg_q         <= oreg_d;
            oreg_valid_q   <= oreg_valid_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) q_mem[wr_ptr_q[AW-1:0]] <= s_arp_lookup_request_u_data_i;
    end

    assign m_timeout_cnt_o  = timeout_cnt_q;
    assign m_spurious_cnt_o = spurious_cnt_q;

    logic [N_STAGES:0]           link_valid, link_ready;
    logic [ARP_LUP_RSP_U_BITS-1:0] link_data [N_STAGES+1];

    assign link_valid[0]           = oreg_valid_q;
    assign link_data[0]            = oreg_q;
    assign slice_ready             = link_ready[0];
    assign link_ready[N_STAGES]    = m_arp_lookup_reply_u_ready_i;
    assign m_arp_lookup_reply_u_valid_o = link_valid[N_STAGES];
    assign m_arp_lookup_reply_u_data_o  = link_data[N_STAGES];

    for (genvar g = 0; g < N_STAGES; g++) begin : g_slice
        meta_reg_slice #(
            .DATA_BITS (ARP_LUP_RSP_U_BITS)
        ) u_slice (
            .aclk      (aclk),
            .aresetn   (aresetn),
            .s_valid_i (link_valid[g]),
            .s_ready_o (link_ready[g]),
            .s_data_i  (link_data[g]),
            .m_valid_o (link_valid[g+1]),
            .m_ready_i (link_ready[g+1]),
            .m_data_o  (link_data[g+1])
        );
    end

endmodule

// File: tb/tb_arp_lookup_reply_tracker.sv
// Directed bench for the ARP reply tracker: stimulus tasks push expected user
// replies into a queue, and a monitor pops and compares each delivered reply.
module tb_arp_lookup_reply_tracker;
    import arp_lookup_reply_tracker_pkg::*;

    localparam int TO = 16;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_data = '0;
    logic        fwd_valid;
    logic        fwd_ready = 1'b1;
    logic [31:0] fwd_data;
    logic        rsp_valid = 1'b0;
    logic        rsp_ready;
    logic [55:0] rsp_data = '0;
    logic        usr_valid;
    logic        usr_ready = 1'b1;
    logic [95:0] usr_data;
    logic [31:0] timeout_cnt, spurious_cnt;

    arp_lookup_reply_tracker #(
        .N_STAGES       (2),
        .N_OUTSTANDING  (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .aclk                           (aclk),
        .aresetn                        (aresetn),
        .s_arp_lookup_request_u_valid_i (req_valid),
        .s_arp_lookup_request_u_ready_o (req_ready),
        .s_arp_lookup_request_u_data_i  (req_data),
        .m_arp_lookup_request_n_valid_o (fwd_valid),
        .m_arp_lookup_request_n_ready_i (fwd_ready),
        .m_arp_lookup_request_n_data_o  (fwd_data),
        .s_arp_lookup_reply_n_valid_i   (rsp_valid),
        .s_arp_lookup_reply_n_ready_o   (rsp_ready),
        .s_arp_lookup_reply_n_data_i    (rsp_data),
        .m_arp_lookup_reply_u_valid_o   (usr_valid),
        .m_arp_lookup_reply_u_ready_i   (usr_ready),
        .m_arp_lookup_reply_u_data_o    (usr_data),
        .m_timeout_cnt_o                (timeout_cnt),
        .m_spurious_cnt_o               (spurious_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int out_cnt  = 0;
    int out_cyc  = 0;
    logic [95:0] exp_q[$];

    function automatic logic [95:0] mk(input logic [31:0] ip, input logic to,
                                       input logic hit, input logic [47:0] mac);
        return {ip, 14'h0, to, hit, mac};
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    always @(negedge aclk) begin
        if (aresetn && usr_valid && usr_ready) begin
            out_cnt++;
            out_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_reply: got %h expected none", usr_data);
            end else begin
                chk("user_reply", usr_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic wait_req_hs(input logic [31:0] ip, output int hs_cyc);
        int  n = 0;
        bit  ok = 0;
        hs_cyc = -1;
        while (n < 200 && !ok) begin
            @(negedge aclk);
            if (req_ready) ok = 1;
            else n++;
        end
        if (!ok) fail_bound("req_handshake");
        else begin
            hs_cyc = cyc;
            chk("fwd_req", {63'h0, fwd_valid, fwd_data}, {63'h0, 1'b1, ip});
        end
        @(posedge aclk); #1;
        req_valid = 1'b0;
    endtask

    task automatic send_req(input logic [31:0] ip, output int hs_cyc);
        req_valid = 1'b1;
        req_data  = ip;
        wait_req_hs(ip, hs_cyc);
    endtask

    task automatic send_rsp(input logic hit, input logic [47:0] mac, output int hs_cyc);
        int n = 0;
        bit ok = 0;
        hs_cyc    = -1;
        rsp_valid = 1'b1;
        rsp_data  = {7'h0, hit, mac};
        while (n < 200 && !ok) begin
            @(negedge aclk);
            if (rsp_ready) ok = 1;
            else n++;
        end
        if (!ok) fail_bound("rsp_handshake");
        else hs_cyc = cyc;
        @(posedge aclk); #1;
        rsp_valid = 1'b0;
    endtask

    task automatic wait_out(input int base);
        int n = 0;
        while (out_cnt <= base && n < 100) begin
            @(posedge aclk); #1;
            n++;
        end
        if (out_cnt <= base) fail_bound("user_reply_wait");
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge aclk); #1;
            n++;
        end
        if (exp_q.size() != 0) fail_bound("drain");
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c, rc, base;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_usr_valid", {95'h0, usr_valid}, 96'h0);
        chk("rst_fwd_valid", {95'h0, fwd_valid}, 96'h0);
        chk("rst_req_ready", {95'h0, req_ready}, 96'h1);
        chk("rst_rsp_ready", {95'h0, rsp_ready}, 96'h1);
        chk("rst_timeout_cnt", {64'h0, timeout_cnt}, 96'h0);
        chk("rst_spurious_cnt", {64'h0, spurious_cnt}, 96'h0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        idle(2);

        // Basic lookup, reply three cycles after the request.
        send_req(32'h0A00000B, c);
        idle(2);
        exp_q.push_back(mk(32'h0A00000B, 1'b0, 1'b1, 48'h001122334455));
        base = out_cnt;
        send_rsp(1'b1, 48'h001122334455, rc);
        wait_out(base);
        chk("reply_latency", 96'(out_cyc - rc), 96'd3);

        // Fill the queue, fifth request must stall until the first reply.
        for (int i = 1; i <= 4; i++) send_req(32'h0A000000 + 32'(i), c);
        req_valid = 1'b1;
        req_data  = 32'h0A000005;
        @(negedge aclk);
        chk("full_req_ready", {95'h0, req_ready}, 96'h0);
        chk("full_fwd_valid", {95'h0, fwd_valid}, 96'h0);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("full_req_ready2", {95'h0, req_ready}, 96'h0);
        @(posedge aclk); #1;
        exp_q.push_back(mk(32'h0A000001, 1'b0, 1'b1, 48'hAAAA00000001));
        send_rsp(1'b1, 48'hAAAA00000001, rc);
        wait_req_hs(32'h0A000005, c);
        exp_q.push_back(mk(32'h0A000002, 1'b0, 1'b0, 48'h000000000000));
        send_rsp(1'b0, 48'h000000000000, rc);
        exp_q.push_back(mk(32'h0A000003, 1'b0, 1'b1, 48'hAAAA00000003));
        send_rsp(1'b1, 48'hAAAA00000003, rc);
        exp_q.push_back(mk(32'h0A000004, 1'b0, 1'b1, 48'hFFFFFFFFFFFF));
        send_rsp(1'b1, 48'hFFFFFFFFFFFF, rc);
        exp_q.push_back(mk(32'h0A000005, 1'b0, 1'b1, 48'h123456789ABC));
        send_rsp(1'b1, 48'h123456789ABC, rc);
        wait_drain();

        // Timeout: no stack reply for one lookup.
        base = out_cnt;
        send_req(32'h0A000063, c);
        exp_q.push_back(mk(32'h0A000063, 1'b1, 1'b0, 48'h0));
        wait_out(base);
        chk("timeout_latency", 96'(out_cyc - c), 96'd20);
        chk("timeout_cnt_1", {64'h0, timeout_cnt}, 96'd1);
        chk("spurious_cnt_0", {64'h0, spurious_cnt}, 96'd0);

        // The late reply for the timed-out lookup is owed and discarded.
        send_rsp(1'b1, 48'h0000DEADBEEF, rc);
        idle(4);
        chk("late_spurious_cnt", {64'h0, spurious_cnt}, 96'd1);

        // Reply with nothing pending.
        send_rsp(1'b1, 48'h0000CAFEF00D, rc);
        idle(4);
        chk("empty_spurious_cnt", {64'h0, spurious_cnt}, 96'd2);
        chk("empty_timeout_cnt", {64'h0, timeout_cnt}, 96'd1);

        // Reply handshake lands on the cycle the timeout would fire.
        base = out_cnt;
        send_req(32'h0A000077, c);
        while (cyc < c + 17) begin
            @(posedge aclk); #1;
        end
        exp_q.push_back(mk(32'h0A000077, 1'b0, 1'b1, 48'h0A0B0C0D0E0F));
        send_rsp(1'b1, 48'h0A0B0C0D0E0F, rc);
        chk("coincide_hs_cycle", 96'(rc - c), 96'd17);
        wait_out(base);
        idle(TO + 6);
        chk("coincide_timeout_cnt", {64'h0, timeout_cnt}, 96'd1);
        chk("coincide_spurious_cnt", {64'h0, spurious_cnt}, 96'd2);

        // Reset in the middle of stalled traffic.
        usr_ready = 1'b0;
        send_req(32'h0A000101, c);
        send_req(32'h0A000102, c);
        send_rsp(1'b1, 48'h111111111111, rc);
        send_rsp(1'b1, 48'h222222222222, rc);
        idle(20);
        @(negedge aclk);
        chk("stalled_usr_valid", {95'h0, usr_valid}, 96'h1);
        @(posedge aclk); #3;
        aresetn = 1'b0;
        #1;
        chk("async_rst_usr_valid", {95'h0, usr_valid}, 96'h0);
        chk("async_rst_timeout_cnt", {64'h0, timeout_cnt}, 96'h0);
        chk("async_rst_spurious_cnt", {64'h0, spurious_cnt}, 96'h0);
        idle(2);
        aresetn   = 1'b1;
        usr_ready = 1'b1;
        idle(10);
        chk("post_rst_usr_valid", {95'h0, usr_valid}, 96'h0);
        chk("post_rst_req_ready", {95'h0, req_ready}, 96'h1);
        chk("post_rst_timeout_cnt", {64'h0, timeout_cnt}, 96'h0);
        chk("post_rst_spurious_cnt", {64'h0, spurious_cnt}, 96'h0);

        // Normal operation resumes after reset.
        send_req(32'h0A000201, c);
        exp_q.push_back(mk(32'h0A000201, 1'b0, 1'b1, 48'h5A5A5A5A5A5A));
        send_rsp(1'b1, 48'h5A5A5A5A5A5A, rc);
        wait_drain();
        idle(4);
        chk("final_queue_empty", 96'(exp_q.size()), 96'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
